// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter sanity checks for the synchronous threshold FIFO family.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Count must represent 0..DEPTH inclusive, hence DEPTH+1 distinct values.
    function automatic int cnt_w_of(input int addr_w);
        return clog2(depth_of(addr_w) + 1);
    endfunction

    function automatic bit thresh_ok(input int addr_w, input int af_level, input int ae_level);
        return (addr_w >= 1) &&
               (af_level >= 1) && (af_level <= depth_of(addr_w)) &&
               (ae_level >= 0) && (ae_level <= depth_of(addr_w) - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_thresh_if.sv
// Producer/consumer bus of the threshold FIFO; master drives requests, slave is the FIFO.
interface fifo_sync_thresh_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic                            wr;
    logic [DATA_W-1:0]               w_data;
    logic                            rd;
    logic [DATA_W-1:0]               r_data;
    logic                            full;
    logic                            empty;
    logic                            almost_full;
    logic                            almost_empty;
    logic [cnt_w_of(ADDR_W)-1:0]     count;
    logic                            err_clr;
    logic                            overflow;
    logic                            underflow;

    modport master (
        output wr, w_data, rd, err_clr,
        input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd, err_clr,
        output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous (show-ahead) read port.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = depth_of(ADDR_W);

    // Storage is deliberately not reset; content is only observable once written.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_sync_thresh.sv
// Parametrised single-clock FIFO with occupancy count and almost-full/empty thresholds.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_sync_thresh
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = depth_of(ADDR_W) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic               clk,
    input  logic               reset,
    fifo_sync_thresh_if.slave  bus
);
    localparam int DEPTH = depth_of(ADDR_W);
    localparam int CNT_W = cnt_w_of(ADDR_W);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    generate
        if (!thresh_ok(ADDR_W, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
            $error("fifo_sync_thresh: ADDR_W/AF_LEVEL/AE_LEVEL out of range");
        end
    endgenerate

    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              almost_full_q, almost_full_d;
    logic              almost_empty_q, almost_empty_d;

    // A write into a full FIFO is still accepted when the same cycle pops the head.
    always_comb begin
        wr_acc         = bus.wr & (~full_q | bus.rd);
        rd_acc         = bus.rd & ~empty_q;
        w_ptr_d        = w_ptr_q + ADDR_W'(wr_acc);
        r_ptr_d        = r_ptr_q + ADDR_W'(rd_acc);
        count_d        = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q        <= '0;
            r_ptr_q        <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            w_ptr_q        <= w_ptr_d;
            r_ptr_q        <= r_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Clearing wins over a same-cycle offending request.
    always_comb begin
        overflow_d  = overflow_q  | (bus.wr & ~wr_acc);
        underflow_d = underflow_q | (bus.rd & empty_q);
        if (bus.err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

    fifo_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (w_ptr_q),
        .wdata (bus.w_data),
        .raddr (r_ptr_q),
        .rdata (bus.r_data)
    );

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.count        = count_q;
endmodule

// File: doc/fifo_sync_thresh.md
# fifo_sync_thresh

Parametrised synchronous single-clock FIFO, the successor to the team's fixed 8×8 FIFO controller. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and defined simultaneous read/write behaviour at full and empty. Optional sticky overflow/underflow error flags are also provided. It sits between producer and consumer blocks as the standard elastic buffer in datapaths.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 3, address bits; depth DEPTH = 2**ADDR_W (ADDR_W ≥ 1)
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- wr  in  1  write request
- w_data  in  DATA_W  write word
- rd  in  1  read request (pop)
- r_data  out  DATA_W  head word, show-ahead; valid while empty=0
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  ADDR_W+1  current occupancy 0..DEPTH
- err_clr  in  1  synchronous clear of sticky error flags
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset values: w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Storage is not cleared, so r_data is undefined until the first write.
- Accept rules, evaluated on registered state:
  - wr_acc = wr & (~full | rd)
  - rd_acc = rd & ~empty
- Accepted write: mem[w_ptr] ← w_data, w_ptr+1.
- Accepted read: r_ptr+1.
- Pointers wrap modulo DEPTH through natural ADDR_W-bit overflow.
- count_next = count + wr_acc − rd_acc, ADDR_W+1 bits, never outside 0..DEPTH.
- Simultaneous wr&rd:
  - not empty, not full: both accepted, count unchanged.
  - full: both accepted. The head word is popped and the new word is written into the freed slot. full stays 1.
  - empty: write accepted, read rejected. underflow is set, and count becomes 1.
- Flags full/empty/almost_* are registered and computed from count_next. They never glitch.
- Single state: no FSM beyond pointers and count. Pointer compare is not used; full/empty derive only from count.

## Timing
- Write-to-read latency: a word written at edge N appears on r_data after edge N when the FIFO was empty. Otherwise it appears when it reaches the head.
- r_data is combinational from mem[r_ptr] and changes only after an edge that moves r_ptr or writes the head slot of an empty FIFO.
- count and all flags update on the same edge that accepts the operation.
- Sticky errors set on the edge after the offending request. err_clr takes priority over a same-cycle set.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Requests during reset are ignored.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - overflow and underflow are implemented as described.
  - err_clr is functional.
- FIFO_ERR_FLAGS_EN undefined:
  - overflow and underflow are tied to 0.
  - err_clr is ignored.
  - The ports remain, so the interface is unchanged.
- All other behaviour is identical in both builds.

## Structure
- Shared package fifo_pkg holds:
  - the DEPTH and count-width localparam functions (clog2 helper)
  - threshold range checks as elaboration-time assertions
- One sub-module: fifo_regfile, a DEPTH×DATA_W array with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata).
- Pointer, count and flag logic stay in fifo_sync_thresh.

## Test plan
- Reset, then fill with DATA_W=8, ADDR_W=3: write 0x01..0x08 → count steps 1..8. almost_full rises at count 7, full at 8. A 9th write sets overflow, and count stays 8.
- Drain after fill: read 8 times → r_data sequence 0x01..0x08. almost_empty at count 1, empty at 0. A 9th read sets underflow, and r_ptr is unchanged.
- Wrap-around: 5 writes, 5 reads, then 6 writes of 0xA0..0xA5 → reads return 0xA0..0xA5 in order across the pointer wrap.
- Simultaneous wr&rd:
  - at full: write 0xFF → head pops, count stays 8, and 0xFF is read last.
  - at empty: count→1, underflow=1, r_data=written word.
- Error clear and reset: assert err_clr → overflow/underflow drop next edge. Assert reset asynchronously with count=4 → count=0 and empty=1 immediately. With FIFO_ERR_FLAGS_EN undefined, error flags stay 0 throughout.
